// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// default mult/div timeout and the bit positions of the latch-enable vector.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam int MD_TIMEOUT_DEFAULT = 64;

    localparam int EN_PC  = 0;
    localparam int EN_FD  = 1;
    localparam int EN_DX  = 2;
    localparam int EN_XM  = 3;
    localparam int EN_MW  = 4;
    localparam int EN_NUM = 5;

endpackage

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// Saturating up-counter used for the optional pipeline performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline latch-enable / flush sequencer for stalls, taken branches and mult/div waits.
// Define STALL_PERF_EN to build the stall/flush/mult-div-wait performance counters.
module pipeline_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_req,
    input  logic             branch_taken_dx,
    input  logic             md_start_dx,
    input  logic             md_ready,
    input  logic             halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_go,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] md_wait_cycles
);

    localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] MD_LAST = TW'(MD_TIMEOUT - 1);

    state_t            state_reg;
    logic [TW-1:0]     md_cnt_reg;
    logic              md_timeout_reg;
    logic [EN_NUM-1:0] en;
    logic              fd_fl, dx_fl, xm_fl, go, busy, release_md;

    always_comb begin
        en         = '0;
        fd_fl      = 1'b0;
        dx_fl      = 1'b0;
        xm_fl      = 1'b0;
        go         = 1'b0;
        busy       = 1'b0;
        release_md = 1'b0;
        if (!reset_n) begin
            en = '0;
        end else if (state_reg == RUN) begin
            if (halt) begin
                en = '0;
            end else if (md_start_dx) begin
                go        = 1'b1;
                en[EN_XM] = 1'b1;
                en[EN_MW] = 1'b1;
                xm_fl     = 1'b1;
            end else if (branch_taken_dx) begin
                en    = '1;
                fd_fl = 1'b1;
                dx_fl = 1'b1;
            end else if (stall_req) begin
                en[EN_DX] = 1'b1;
                en[EN_XM] = 1'b1;
                en[EN_MW] = 1'b1;
                dx_fl     = 1'b1;
            end else begin
                en = '1;
            end
        end else begin
            busy = 1'b1;
            if (halt) begin
                en = '0;
            end else if (md_ready || (md_cnt_reg == MD_LAST)) begin
                // Result (or forced release) enters XM on this edge.
                en         = '1;
                release_md = 1'b1;
            end else begin
                en[EN_XM] = 1'b1;
                en[EN_MW] = 1'b1;
                xm_fl     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= RUN;
            md_cnt_reg     <= '0;
            md_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (!halt && md_start_dx) begin
                        state_reg  <= MD_WAIT;
                        md_cnt_reg <= '0;
                    end
                end
                MD_WAIT: begin
                    if (!halt) begin
                        if (release_md) begin
                            state_reg <= RUN;
                            if (!md_ready) begin
                                md_timeout_reg <= 1'b1;
                            end
                        end else begin
                            md_cnt_reg <= md_cnt_reg + TW'(1);
                        end
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign pc_en      = en[EN_PC];
    assign fd_en      = en[EN_FD];
    assign dx_en      = en[EN_DX];
    assign xm_en      = en[EN_XM];
    assign mw_en      = en[EN_MW];
    assign fd_flush   = fd_fl;
    assign dx_flush   = dx_fl;
    assign xm_flush   = xm_fl;
    assign md_go      = go;
    assign md_busy    = busy;
    assign md_timeout = md_timeout_reg;

`ifdef STALL_PERF_EN
    logic [2:0]       perf_inc;
    logic [CNT_W-1:0] perf_cnt [3];

    // Halt cycles are frozen time, not stalls, so they are excluded.
    assign perf_inc[0] = reset_n && (state_reg == RUN) && !halt && !en[EN_PC];
    assign perf_inc[1] = reset_n && (state_reg == RUN) && !halt && !md_start_dx && branch_taken_dx;
    assign perf_inc[2] = reset_n && (state_reg == MD_WAIT);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clock   (clock),
                .reset_n (reset_n),
                .inc     (perf_inc[gi]),
                .clear   (1'b0),
                .count   (perf_cnt[gi])
            );
        end
    endgenerate

    assign stall_cycles   = perf_cnt[0];
    assign flush_count    = perf_cnt[1];
    assign md_wait_cycles = perf_cnt[2];
`else
    assign stall_cycles   = '0;
    assign flush_count    = '0;
    assign md_wait_cycles = '0;
`endif

endmodule
